// File: rtl/goofy_alu_pkg.sv
// Shared constants for the goofy sequential ALU: opcodes, FSM states, flag bit positions.
package goofy_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADC  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SBC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_CMP  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;
    localparam logic [3:0] OP_HLT  = 4'd12;
    localparam logic [3:0] OP_FCLR = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FLAGS_W   = 5;
    localparam int FLG_CARRY = 0;
    localparam int FLG_EQ    = 1;
    localparam int FLG_ZERO  = 2;
    localparam int FLG_NEG   = 3;
    localparam int FLG_HLT   = 4;

    // Ops whose result is ready one cycle after accept (illegal codes yield a zero result).
    function automatic logic op_is_single(input logic [3:0] op);
        return (op <= OP_CMP) || (op > OP_FCLR);
    endfunction

endpackage

// File: rtl/goofy_alu_seq_if.sv
// Operand, request and result signals of goofy_alu_seq bundled as one interface.
interface goofy_alu_seq_if #(parameter int WIDTH = 8);
    logic             a_we;
    logic             b_we;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic             op_valid;
    logic [3:0]       op_code;
    logic             op_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [WIDTH-1:0] out_hi;
    logic [4:0]       flags_o;

    modport slave (
        input  a_we, b_we, a_d, b_d, op_valid, op_code, out_ready,
        output a_o, b_o, op_ready, out_valid, out_data, out_hi, flags_o
    );

    modport master (
        output a_we, b_we, a_d, b_d, op_valid, op_code, out_ready,
        input  a_o, b_o, op_ready, out_valid, out_data, out_hi, flags_o
    );
endinterface

// File: rtl/goofy_alu_mul.sv
// Unsigned shift-add multiplier: one partial-product step per cycle, WIDTH steps after start.
module goofy_alu_mul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic [WIDTH:0]     part;

    // Upper half accumulates, lower half holds the remaining multiplier bits.
    assign part    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    assign done    = busy && (cnt == '0);
    assign product = acc;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt != '0) begin
                acc <= {part, acc[WIDTH-1:1]};
                cnt <= cnt - CW'(1);
            end else begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/goofy_alu_seq.sv
// Sequential ALU with operand registers, sticky flags, halt state and a multi-cycle multiplier.
module goofy_alu_seq
    import goofy_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  res,
    goofy_alu_seq_if.slave        bus
);
    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q, out_lo_q, out_hi_q;
    logic [FLAGS_W-1:0]   flags_q, alu_flags;
    logic [WIDTH-1:0]     alu_lo;
    logic [WIDTH:0]       sum, diff;
    logic                 accept, drop, take, mul_start, mul_done;
    logic [2*WIDTH-1:0]   mul_prod;

    assign accept    = bus.op_valid & bus.op_ready;
    // A halted core swallows everything except FCLR.
    assign drop      = accept & flags_q[FLG_HLT] & (bus.op_code != OP_FCLR);
    assign take      = accept & ~drop;
    assign mul_start = take & (bus.op_code == OP_MUL);

    assign bus.a_o      = a_q;
    assign bus.b_o      = b_q;
    assign bus.out_data = out_lo_q;
    assign bus.out_hi   = out_hi_q;
    assign bus.flags_o  = flags_q;

    goofy_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .res     (res),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle datapath works on the register values present at the accept edge.
    always_comb begin
        sum  = {1'b0, a_q} + {1'b0, b_q}
             + {{WIDTH{1'b0}}, (bus.op_code == OP_ADC) & flags_q[FLG_CARRY]};
        diff = {1'b0, a_q} - {1'b0, b_q}
             - {{WIDTH{1'b0}}, (bus.op_code == OP_SBC) & flags_q[FLG_CARRY]};
        alu_lo    = '0;
        alu_flags = flags_q;
        case (bus.op_code)
            OP_ADD, OP_ADC: begin
                alu_lo               = sum[WIDTH-1:0];
                alu_flags[FLG_CARRY] = sum[WIDTH];
            end
            OP_SUB, OP_SBC, OP_CMP: begin
                alu_lo               = diff[WIDTH-1:0];
                alu_flags[FLG_CARRY] = diff[WIDTH];
            end
            OP_AND: alu_lo = a_q & b_q;
            OP_OR:  alu_lo = a_q | b_q;
            OP_XOR: alu_lo = a_q ^ b_q;
            OP_NOT: alu_lo = ~a_q;
            OP_SHL: begin
                alu_lo               = {a_q[WIDTH-2:0], 1'b0};
                alu_flags[FLG_CARRY] = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_lo               = {1'b0, a_q[WIDTH-1:1]};
                alu_flags[FLG_CARRY] = a_q[0];
            end
            OP_HLT:  alu_flags[FLG_HLT] = 1'b1;
            OP_FCLR: alu_flags = '0;
            default: ;
        endcase
        if (bus.op_code == OP_CMP)
            alu_flags[FLG_EQ] = (a_q == b_q);
        if (bus.op_code <= OP_CMP) begin
            alu_flags[FLG_ZERO] = (alu_lo == '0);
            alu_flags[FLG_NEG]  = alu_lo[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bus.op_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.op_ready = res;
                if (take) begin
                    if (bus.op_code == OP_MUL)
                        state_d = ST_BUSY;
                    else if (op_is_single(bus.op_code))
                        state_d = ST_DONE;
                end
            end
            ST_BUSY: if (mul_done) state_d = ST_DONE;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            a_q      <= '0;
            b_q      <= '0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
        end else begin
            if (bus.a_we) a_q <= bus.a_d;
            if (bus.b_we) b_q <= bus.b_d;
            if (take) begin
                flags_q <= alu_flags;
                if (op_is_single(bus.op_code)) begin
                    out_lo_q <= alu_lo;
                    out_hi_q <= '0;
                end
            end
            if (state_q == ST_BUSY && mul_done) begin
                out_lo_q            <= mul_prod[WIDTH-1:0];
                out_hi_q            <= mul_prod[2*WIDTH-1:WIDTH];
                flags_q[FLG_CARRY]  <= (mul_prod[2*WIDTH-1:WIDTH] != '0);
                flags_q[FLG_ZERO]   <= (mul_prod == '0);
                flags_q[FLG_NEG]    <= mul_prod[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_goofy_alu_seq.sv
// Directed test of goofy_alu_seq at WIDTH=8 with hand-computed expectations.
module tb_goofy_alu_seq;
    import goofy_alu_pkg::*;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    goofy_alu_seq_if #(.WIDTH(8)) bus ();

    goofy_alu_seq #(.WIDTH(8)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk_d(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_f(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] b);
        bus.a_we = 1'b1; bus.a_d = a;
        bus.b_we = 1'b1; bus.b_d = b;
        tick();
        bus.a_we = 1'b0;
        bus.b_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk_b("consume_valid", bus.out_valid, 1'b0);
        chk_b("consume_ready", bus.op_ready, 1'b1);
    endtask

    // Flags are {hlt, neg, zero, eq, carry}.
    initial begin
        bus.a_we = 1'b0; bus.b_we = 1'b0; bus.a_d = '0; bus.b_d = '0;
        bus.op_valid = 1'b0; bus.op_code = '0; bus.out_ready = 1'b0;

        tick();
        chk_b("rst_ready", bus.op_ready, 1'b0);
        chk_b("rst_valid", bus.out_valid, 1'b0);
        chk_f("rst_flags", bus.flags_o, 5'b00000);
        chk_d("rst_data", bus.out_data, 8'h00);
        @(negedge clk);
        res = 1'b1;
        #1;
        chk_b("post_rst_ready", bus.op_ready, 1'b1);
        tick();

        wr(8'd200, 8'd100);
        chk_d("a_o", bus.a_o, 8'd200);
        chk_d("b_o", bus.b_o, 8'd100);
        issue(OP_ADD);
        chk_b("add_valid", bus.out_valid, 1'b1);
        chk_d("add_data", bus.out_data, 8'd44);
        chk_f("add_flags", bus.flags_o, 5'b00001);
        chk_b("add_ready", bus.op_ready, 1'b0);
        consume();

        wr(8'd1, 8'd1);
        issue(OP_ADC);
        chk_d("adc_data", bus.out_data, 8'd3);
        chk_f("adc_flags", bus.flags_o, 5'b00000);
        consume();

        wr(8'd5, 8'd7);
        issue(OP_SUB);
        chk_d("sub_data", bus.out_data, 8'hFE);
        chk_f("sub_flags", bus.flags_o, 5'b01001);
        consume();

        wr(8'd0, 8'd0);
        issue(OP_SBC);
        chk_d("sbc_data", bus.out_data, 8'hFF);
        chk_f("sbc_flags", bus.flags_o, 5'b01001);
        consume();

        wr(8'd9, 8'd9);
        issue(OP_CMP);
        chk_d("cmp_data", bus.out_data, 8'h00);
        chk_f("cmp_flags", bus.flags_o, 5'b00110);
        consume();

        wr(8'hF0, 8'h3C);
        issue(OP_AND);
        chk_d("and_data", bus.out_data, 8'h30);
        chk_f("and_flags", bus.flags_o, 5'b00010);
        consume();

        wr(8'h81, 8'h00);
        issue(OP_SHL);
        chk_d("shl_data", bus.out_data, 8'h02);
        chk_f("shl_flags", bus.flags_o, 5'b00011);
        consume();

        wr(8'h82, 8'h00);
        issue(OP_SHR);
        chk_d("shr_data", bus.out_data, 8'h41);
        chk_f("shr_flags", bus.flags_o, 5'b00010);
        consume();

        wr(8'd255, 8'd255);
        issue(OP_MUL);
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin
                bus.a_we = 1'b1;
                bus.a_d  = 8'd0;
            end
            tick();
            bus.a_we = 1'b0;
            chk_b("mul_busy_valid", bus.out_valid, 1'b0);
            chk_b("mul_busy_ready", bus.op_ready, 1'b0);
        end
        tick();
        chk_b("mul_valid", bus.out_valid, 1'b1);
        chk_d("mul_hi", bus.out_hi, 8'hFE);
        chk_d("mul_lo", bus.out_data, 8'h01);
        chk_f("mul_flags", bus.flags_o, 5'b00011);
        chk_d("mul_a_written", bus.a_o, 8'h00);

        for (int i = 0; i < 3; i++) begin
            tick();
            chk_b("hold_valid", bus.out_valid, 1'b1);
            chk_d("hold_data", bus.out_data, 8'h01);
            chk_b("hold_ready", bus.op_ready, 1'b0);
        end
        consume();

        issue(OP_HLT);
        chk_f("hlt_flags", bus.flags_o, 5'b10011);
        chk_b("hlt_valid", bus.out_valid, 1'b0);
        chk_b("hlt_ready", bus.op_ready, 1'b1);
        wr(8'd1, 8'd2);
        issue(OP_ADD);
        chk_b("halted_add_valid", bus.out_valid, 1'b0);
        chk_f("halted_add_flags", bus.flags_o, 5'b10011);
        tick();
        chk_b("halted_add_valid2", bus.out_valid, 1'b0);

        issue(OP_FCLR);
        chk_f("fclr_flags", bus.flags_o, 5'b00000);
        chk_b("fclr_valid", bus.out_valid, 1'b0);
        issue(OP_ADD);
        chk_b("post_fclr_valid", bus.out_valid, 1'b1);
        chk_d("post_fclr_data", bus.out_data, 8'd3);
        chk_d("post_fclr_hi", bus.out_hi, 8'h00);
        consume();

        wr(8'h90, 8'h80);
        issue(OP_ADD);
        chk_d("add2_data", bus.out_data, 8'h10);
        chk_f("add2_flags", bus.flags_o, 5'b00001);
        consume();
        issue(4'd14);
        chk_b("illegal_valid", bus.out_valid, 1'b1);
        chk_d("illegal_data", bus.out_data, 8'h00);
        chk_d("illegal_hi", bus.out_hi, 8'h00);
        chk_f("illegal_flags", bus.flags_o, 5'b00001);
        consume();

        wr(8'd3, 8'd5);
        issue(OP_MUL);
        tick(); tick(); tick();
        res = 1'b0;
        #1;
        chk_b("abort_valid", bus.out_valid, 1'b0);
        chk_b("abort_ready", bus.op_ready, 1'b0);
        chk_d("abort_a", bus.a_o, 8'h00);
        chk_d("abort_b", bus.b_o, 8'h00);
        chk_d("abort_data", bus.out_data, 8'h00);
        chk_d("abort_hi", bus.out_hi, 8'h00);
        chk_f("abort_flags", bus.flags_o, 5'b00000);
        @(negedge clk);
        res = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_b("abort_no_result", bus.out_valid, 1'b0);
        end
        chk_b("abort_idle_ready", bus.op_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
